// File: rtl/led_ram_arbiter.sv
// led_ram_arbiter: owns the single port of the 8x8x4 LED display RAM. Three clients share it:
// the scan refresher (reads), the light-pen writer (writes) and a built-in clear-screen
// sequencer that writes CLR_VALUE to all 64 cells.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   scan_req_i/row/col    scan read request; scan_gnt_o accepts it (combinational)
//   scan_rvalid_o/rdata_o read data, two cycles after grant; rdata holds when not valid
//   pen_valid_i/row/col/data  pen write request; pen_ready_o accepts it (combinational)
//   clr_start_i           start full-screen clear (ignored while clr_busy_o)
//   clr_busy_o/clr_done_o clear in progress / one-cycle completion pulse
//   ram_data_o/row/col/we registered RAM port drive; ram_rdata_i is the RAM read data
//   pen_stall_cnt_o       only with LED_ARB_STALL_CNT_EN: saturating count of pen stall cycles
//
// Optional feature macro: LED_ARB_STALL_CNT_EN.

module led_ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [3:0]  CLR_VALUE    = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_req_i,
    input  logic [2:0]  scan_row_i,
    input  logic [2:0]  scan_col_i,
    output logic        scan_gnt_o,
    output logic        scan_rvalid_o,
    output logic [3:0]  scan_rdata_o,
    input  logic        pen_valid_i,
    input  logic [2:0]  pen_row_i,
    input  logic [2:0]  pen_col_i,
    input  logic [3:0]  pen_data_i,
    output logic        pen_ready_o,
    input  logic        clr_start_i,
    output logic        clr_busy_o,
    output logic        clr_done_o,
`ifdef LED_ARB_STALL_CNT_EN
    output logic [15:0] pen_stall_cnt_o,
`endif
    output logic [3:0]  ram_data_o,
    output logic [2:0]  ram_row_o,
    output logic [2:0]  ram_col_o,
    output logic        ram_we_o,
    input  logic [3:0]  ram_rdata_i
);

    typedef enum logic {StServe, StClear} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e     state_q;
    logic [5:0] clr_cnt_q;
    logic [3:0] starve_q;
    logic       rd_pend_q;      // scan read addressing the RAM this cycle
    logic       scan_rvalid_q;  // RAM output holds scan data this cycle
    logic [3:0] rdata_hold_q;
    logic       clr_done_q;
    logic [3:0] ram_data_q;
    logic [2:0] ram_row_q;
    logic [2:0] ram_col_q;
    logic       ram_we_q;

    logic starved;
    assign starved = (starve_q == StarveMax);

    always_comb begin
        scan_gnt_o  = 1'b0;
        pen_ready_o = 1'b0;
        if (state_q == StServe && !clr_start_i) begin
            if (pen_valid_i && starved) begin
                pen_ready_o = 1'b1;
            end else if (scan_req_i) begin
                scan_gnt_o = 1'b1;
            end else if (pen_valid_i) begin
                pen_ready_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StServe;
            clr_cnt_q     <= 6'd0;
            starve_q      <= 4'd0;
            rd_pend_q     <= 1'b0;
            scan_rvalid_q <= 1'b0;
            rdata_hold_q  <= 4'd0;
            clr_done_q    <= 1'b0;
            ram_data_q    <= 4'd0;
            ram_row_q     <= 3'd0;
            ram_col_q     <= 3'd0;
            ram_we_q      <= 1'b0;
        end else begin
            rd_pend_q     <= scan_gnt_o;
            scan_rvalid_q <= rd_pend_q;
            if (scan_rvalid_q) begin
                rdata_hold_q <= ram_rdata_i;
            end
            clr_done_q <= 1'b0;
            ram_we_q   <= 1'b0;
            case (state_q)
                StServe: begin
                    if (clr_start_i) begin
                        state_q   <= StClear;
                        clr_cnt_q <= 6'd0;
                    end else if (pen_ready_o) begin
                        ram_row_q  <= pen_row_i;
                        ram_col_q  <= pen_col_i;
                        ram_data_q <= pen_data_i;
                        ram_we_q   <= 1'b1;
                    end else if (scan_gnt_o) begin
                        ram_row_q <= scan_row_i;
                        ram_col_q <= scan_col_i;
                    end
                    if (pen_ready_o) begin
                        starve_q <= 4'd0;
                    end else if (pen_valid_i && !starved) begin
                        starve_q <= starve_q + 4'd1;
                    end
                end
                StClear: begin
                    ram_row_q  <= clr_cnt_q[5:3];
                    ram_col_q  <= clr_cnt_q[2:0];
                    ram_data_q <= CLR_VALUE;
                    ram_we_q   <= 1'b1;
                    clr_cnt_q  <= clr_cnt_q + 6'd1;
                    if (clr_cnt_q == 6'd63) begin
                        state_q    <= StServe;
                        clr_done_q <= 1'b1;
                    end
                end
                default: state_q <= StServe;
            endcase
        end
    end

`ifdef LED_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else if (pen_valid_i && !pen_ready_o && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign pen_stall_cnt_o = stall_cnt_q;
`endif

    // Read data passes straight through in its valid cycle, then holds.
    assign scan_rvalid_o = scan_rvalid_q;
    assign scan_rdata_o  = scan_rvalid_q ? ram_rdata_i : rdata_hold_q;
    assign clr_busy_o    = (state_q == StClear);
    assign clr_done_o    = clr_done_q;
    assign ram_data_o    = ram_data_q;
    assign ram_row_o     = ram_row_q;
    assign ram_col_o     = ram_col_q;
    assign ram_we_o      = ram_we_q;

endmodule

// File: tb/tb_led_ram_arbiter.sv
// Directed bench for led_ram_arbiter with a behavioural model of the registered-read RAM.
module tb_led_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_req;
    logic [2:0] scan_row, scan_col;
    logic       scan_gnt, scan_rvalid;
    logic [3:0] scan_rdata;
    logic       pen_valid;
    logic [2:0] pen_row, pen_col;
    logic [3:0] pen_data;
    logic       pen_ready;
    logic       clr_start, clr_busy, clr_done;
    logic [3:0] ram_data;
    logic [2:0] ram_row, ram_col;
    logic       ram_we;
    logic [3:0] ram_rdata;
`ifdef LED_ARB_STALL_CNT_EN
    logic [15:0] pen_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [3:0] mem     [64];
    logic [3:0] exp_mem [64];
    logic       fill_en  = 1'b0;
    logic       fill_pat = 1'b0;
    logic [3:0] fill_val = 4'h0;

    always #5 clk = ~clk;

    led_ram_arbiter #(.STARVE_LIMIT(4), .CLR_VALUE(4'b0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scan_req_i    (scan_req),
        .scan_row_i    (scan_row),
        .scan_col_i    (scan_col),
        .scan_gnt_o    (scan_gnt),
        .scan_rvalid_o (scan_rvalid),
        .scan_rdata_o  (scan_rdata),
        .pen_valid_i   (pen_valid),
        .pen_row_i     (pen_row),
        .pen_col_i     (pen_col),
        .pen_data_i    (pen_data),
        .pen_ready_o   (pen_ready),
        .clr_start_i   (clr_start),
        .clr_busy_o    (clr_busy),
        .clr_done_o    (clr_done),
`ifdef LED_ARB_STALL_CNT_EN
        .pen_stall_cnt_o (pen_stall_cnt),
`endif
        .ram_data_o    (ram_data),
        .ram_row_o     (ram_row),
        .ram_col_o     (ram_col),
        .ram_we_o      (ram_we),
        .ram_rdata_i   (ram_rdata)
    );

    // RAM model: synchronous write, registered read (old data on collision).
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= fill_pat ? 4'(i) : fill_val;
        end else if (ram_we) begin
            mem[{ram_row, ram_col}] <= ram_data;
        end
        ram_rdata <= mem[{ram_row, ram_col}];
    end

    task automatic idle_inputs();
        scan_req = 0; scan_row = 0; scan_col = 0;
        pen_valid = 0; pen_row = 0; pen_col = 0; pen_data = 0;
        clr_start = 0;
    endtask

    task automatic fill(input bit pat, input logic [3:0] v);
        @(posedge clk); #1;
        idle_inputs();
        fill_en = 1; fill_pat = pat; fill_val = v;
        @(posedge clk); #1;
        fill_en = 0;
        for (int i = 0; i < 64; i++) exp_mem[i] = pat ? 4'(i) : v;
    endtask

    // Pipelined read of all 64 cells, one grant per cycle.
    task automatic sweep(input string name);
        logic [5:0] a;
        for (int k = 0; k < 66; k++) begin
            @(posedge clk); #1;
            idle_inputs();
            a = 6'(k);
            scan_req = (k < 64);
            scan_row = a[5:3];
            scan_col = a[2:0];
            @(negedge clk);
            if (k < 64) begin
                total++;
                if (scan_gnt !== 1'b1) begin
                    bad++;
                    $display("FAIL %s gnt cell %0d: got %b want 1", name, k, scan_gnt);
                end
            end
            if (k >= 2) begin
                total++;
                if (scan_rvalid !== 1'b1 || scan_rdata !== exp_mem[k-2]) begin
                    bad++;
                    $display("FAIL %s read cell %0d: got v=%b d=%h want v=1 d=%h",
                             name, k - 2, scan_rvalid, scan_rdata, exp_mem[k-2]);
                end
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [22:0] outs;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {scan_gnt, scan_rvalid, scan_rdata, pen_ready, clr_busy, clr_done,
                ram_data, ram_row, ram_col, ram_we};
        total++;
        if (outs !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            outs = {scan_gnt, scan_rvalid, scan_rdata, pen_ready, clr_busy, clr_done,
                    ram_data, ram_row, ram_col, ram_we};
            total++;
            if (outs !== 23'd0) begin
                bad++;
                $display("FAIL idle_outputs cycle %0d: got %h want 0", i, outs);
            end
        end
    endtask

    task automatic test_pen_write();
        @(posedge clk); #1;
        pen_valid = 1; pen_row = 3'd2; pen_col = 3'd5; pen_data = 4'b1010;
        @(negedge clk);
        total++;
        if (pen_ready !== 1'b1 || scan_gnt !== 1'b0) begin
            bad++;
            $display("FAIL pen_ready: got rdy=%b gnt=%b want rdy=1 gnt=0", pen_ready, scan_gnt);
        end
        exp_mem[21] = 4'b1010;
        // Scan of the same cell granted in the very next cycle must see the new data.
        @(posedge clk); #1;
        idle_inputs();
        scan_req = 1; scan_row = 3'd2; scan_col = 3'd5;
        @(negedge clk);
        total++;
        if ({ram_we, ram_row, ram_col, ram_data} !== {1'b1, 3'd2, 3'd5, 4'b1010}) begin
            bad++;
            $display("FAIL pen_ram_port: got we=%b r=%0d c=%0d d=%b want 1 2 5 1010",
                     ram_we, ram_row, ram_col, ram_data);
        end
        total++;
        if (scan_gnt !== 1'b1) begin
            bad++;
            $display("FAIL pen_scan_gnt: got %b want 1", scan_gnt);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++;
        if ({scan_rvalid, ram_we, ram_row, ram_col} !== {1'b0, 1'b0, 3'd2, 3'd5}) begin
            bad++;
            $display("FAIL scan_addr_stage: got v=%b we=%b r=%0d c=%0d want 0 0 2 5",
                     scan_rvalid, ram_we, ram_row, ram_col);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (scan_rvalid !== 1'b1 || scan_rdata !== 4'b1010) begin
            bad++;
            $display("FAIL scan_readback: got v=%b d=%b want v=1 d=1010", scan_rvalid, scan_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (scan_rvalid !== 1'b0 || scan_rdata !== 4'b1010) begin
            bad++;
            $display("FAIL scan_hold: got v=%b d=%b want v=0 d=1010", scan_rvalid, scan_rdata);
        end
    endtask

    task automatic test_starve();
        logic want_pen;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            scan_req = 1; scan_row = 3'd0; scan_col = 3'd0;
            pen_valid = 1; pen_row = 3'd7; pen_col = 3'd7; pen_data = 4'h3;
            want_pen = (i % 5 == 4);
            @(negedge clk);
            total++;
            if (pen_ready !== want_pen || scan_gnt !== !want_pen) begin
                bad++;
                $display("FAIL starve cycle %0d: got rdy=%b gnt=%b want rdy=%b gnt=%b",
                         i, pen_ready, scan_gnt, want_pen, !want_pen);
            end
        end
        exp_mem[63] = 4'h3;
        @(posedge clk); #1;
        idle_inputs();
        repeat (3) @(posedge clk);
    endtask

    task automatic test_clear();
        int busy_n = 0, we_n = 0, done_n = 0;
        bit seen_done = 0;
        fill(1'b0, 4'hF);
        @(posedge clk); #1;
        clr_start = 1; scan_req = 1; pen_valid = 1; pen_row = 3'd1;
        @(negedge clk);
        total++;
        if ({scan_gnt, pen_ready, clr_busy} !== 3'b000) begin
            bad++;
            $display("FAIL clr_start_cycle: got gnt=%b rdy=%b busy=%b want 000",
                     scan_gnt, pen_ready, clr_busy);
        end
        for (int i = 0; i < 80 && !seen_done; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            if (clr_busy) busy_n++;
            if (ram_we) begin
                total++;
                if ({ram_row, ram_col} !== 6'(we_n) || ram_data !== 4'h0) begin
                    bad++;
                    $display("FAIL clr_write %0d: got addr=%0d d=%h want addr=%0d d=0",
                             we_n, {ram_row, ram_col}, ram_data, we_n);
                end
                we_n++;
            end
            if (clr_done) begin
                done_n++;
                seen_done = 1;
                total++;
                if (clr_busy !== 1'b0 || busy_n != 64) begin
                    bad++;
                    $display("FAIL clr_done_timing: got busy=%b busy_cycles=%0d want 0 64",
                             clr_busy, busy_n);
                end
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        if (clr_done) done_n++;
        total++;
        if (busy_n != 64 || we_n != 64 || done_n != 1 || ram_we !== 1'b0) begin
            bad++;
            $display("FAIL clr_counts: got busy=%0d we=%0d done=%0d want 64 64 1",
                     busy_n, we_n, done_n);
        end
        for (int i = 0; i < 64; i++) exp_mem[i] = 4'h0;
        sweep("clear_sweep");
    endtask

    task automatic test_clear_restart();
        int busy_n = 0;
        bit seen_done = 0;
        @(posedge clk); #1;
        clr_start = 1;
        pen_valid = 1; pen_row = 3'd1; pen_col = 3'd1; pen_data = 4'h6;
        @(negedge clk);
        total++;
        if (pen_ready !== 1'b0) begin
            bad++;
            $display("FAIL restart_start_pen: got %b want 0", pen_ready);
        end
        for (int i = 0; i < 80 && !seen_done; i++) begin
            @(posedge clk); #1;
            clr_start = (i == 20);
            @(negedge clk);
            if (clr_busy) begin
                busy_n++;
                total++;
                if (pen_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL restart_pen_during_clear cycle %0d: got %b want 0",
                             i, pen_ready);
                end
            end
            if (clr_done) begin
                seen_done = 1;
                total++;
                if (pen_ready !== 1'b1 || busy_n != 64) begin
                    bad++;
                    $display("FAIL restart_done: got rdy=%b busy_cycles=%0d want 1 64",
                             pen_ready, busy_n);
                end
            end
        end
        total++;
        if (!seen_done) begin
            bad++;
            $display("FAIL restart_timeout: got no clr_done want clr_done");
        end
        for (int i = 0; i < 64; i++) exp_mem[i] = 4'h0;
        exp_mem[9] = 4'h6;
        sweep("restart_sweep");
    endtask

    task automatic test_reset_mid_clear();
        bit hit = 0;
        fill(1'b0, 4'hF);
        @(posedge clk); #1;
        clr_start = 1;
        for (int i = 0; i < 80 && !hit; i++) begin
            @(posedge clk); #1;
            clr_start = 0;
            @(negedge clk);
            if (ram_we && {ram_row, ram_col} == 6'd29) hit = 1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL midclr_timeout: got no write to cell 29 want one");
        end
        // Reset right after the posedge that commits cell 29.
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        total++;
        if ({clr_busy, ram_we, clr_done, scan_rvalid} !== 4'b0000) begin
            bad++;
            $display("FAIL midclr_reset_outputs: got busy=%b we=%b done=%b v=%b want 0000",
                     clr_busy, ram_we, clr_done, scan_rvalid);
        end
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 64; i++) exp_mem[i] = (i < 30) ? 4'h0 : 4'hF;
        sweep("midclr_sweep");
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        fill_en = 1; fill_pat = 1;
        for (int i = 0; i < 64; i++) exp_mem[i] = 4'(i);
        @(posedge clk); #1;
        fill_en = 0;
        test_reset();
        test_pen_write();
        test_starve();
        test_clear();
        test_clear_restart();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_ram_arbiter.md
Name: led_ram_arbiter

Overview:
- Owns the single port of the 8x8x4bit LED display RAM (1-cycle registered read, synchronous write).
- Shares that port among three clients:
  - the display scan refresher (reads);
  - the light-pen writer (writes);
  - a built-in clear-screen sequencer (64 writes).
- Sits between the scan/pen logic and the RAM. Drives the RAM's data, row, col and we inputs, and returns the RAM's led_data output to the scan client with a valid strobe.

Parameters:
- STARVE_LIMIT, default 4: consecutive stalled pen cycles after which the pen wins over scan for one grant (range 1..15).
- CLR_VALUE, default 4'b0000: cell value written by the clear sequencer.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- scan_req  in  1  scan read request
- scan_row  in  3  scan read row
- scan_col  in  3  scan read col
- scan_gnt  out  1  scan request accepted this cycle (combinational)
- scan_rvalid  out  1  scan_rdata valid
- scan_rdata  out  4  returned cell data
- pen_valid  in  1  pen write request (held until accepted)
- pen_row  in  3  pen write row
- pen_col  in  3  pen write col
- pen_data  in  4  pen write data {store,G,R,rsvd}
- pen_ready  out  1  pen write accepted this cycle (combinational)
- clr_start  in  1  start full-screen clear (single-cycle pulse)
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when clear finishes
- ram_data  out  4  to RAM data
- ram_row  out  3  to RAM addr_row
- ram_col  out  3  to RAM addr_col
- ram_we  out  1  to RAM we
- ram_rdata  in  4  from RAM led_data

Behaviour:
- Reset (async, rst_n low):
  - state=SERVE, clear counter=0, starve counter=0.
  - All outputs 0: ram_*, scan_gnt, scan_rvalid, scan_rdata, pen_ready, clr_busy, clr_done.
- States: SERVE, CLEAR.
- SERVE, per-cycle priority:
  1. clr_start=1: enter CLEAR next cycle. No scan/pen grant this cycle.
  2. pen_valid=1 and starve counter==STARVE_LIMIT: pen_ready=1.
  3. scan_req=1: scan_gnt=1.
  4. pen_valid=1: pen_ready=1.
  - At most one grant per cycle.
- Starve counter (4 bit):
  - increments when pen_valid=1 and pen_ready=0 in SERVE;
  - saturates at STARVE_LIMIT;
  - clears on pen acceptance;
  - holds during CLEAR.
- RAM port:
  - ram_row/ram_col/ram_data/ram_we are registered.
  - They reflect the winning request one cycle after grant.
  - ram_we=1 only for pen or clear writes; 0 otherwise (idle cycles keep last address, we=0).
- Scan latency:
  - grant in cycle N → RAM addressed in N+1 → scan_rvalid=1 and scan_rdata=ram_rdata in N+2.
  - Fully pipelined: one read per cycle sustainable.
  - scan_rdata holds its last value when scan_rvalid=0.
- Pen write: RAM contents updated at the end of cycle N+1 after pen_ready in cycle N.
  - A scan read of the same cell granted in N+1 or later returns the new data.
- CLEAR:
  - clr_busy=1 from the first CLEAR cycle.
  - Issues 64 consecutive writes of CLR_VALUE, counter 0..63: row=cnt[5:3], col=cnt[2:0].
  - scan_gnt=0 and pen_ready=0 throughout.
  - After the write for cnt=63 is issued: return to SERVE, clr_busy=0, clr_done=1 for exactly one cycle (the first SERVE cycle).
  - Total clr_busy high = 64 cycles.
- clr_start while clr_busy=1: ignored (no restart, no extension).
- In-flight scan reads granted before CLEAR entry still complete, with scan_rvalid at N+2.
- Reset mid-clear: abort immediately; outputs return to reset values; RAM contents partially cleared (not restored).

Optional Feature:
- Macro: LED_ARB_STALL_CNT_EN.
- Defined:
  - extra output pen_stall_cnt out 16: counts cycles with pen_valid=1 and pen_ready=0, including CLEAR cycles;
  - saturates at 16'hFFFF;
  - cleared only by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then idle 5 cycles → all outputs 0, ram_we=0 every cycle.
- Pen write row2 col5 data 4'b1010, no scan → pen_ready=1 same cycle. Next cycle: ram_we=1, row=2, col=5, data=4'b1010. Then a scan of (2,5) → scan_rvalid 2 cycles after grant, scan_rdata=4'b1010.
- scan_req held high continuously with pen_valid high, STARVE_LIMIT=4 → scan granted 4 cycles, pen granted on 5th, pattern repeats; stall count between pen grants = 4.
- clr_start pulse after filling all cells with 4'hF → clr_busy high exactly 64 cycles, 64 ram_we pulses with addresses 0..63 row-major, clr_done one pulse; a subsequent scan of all 64 cells returns 4'h0.
- clr_start during clear at cycle 20 and simultaneous with pen_valid → clear not restarted (still 64 cycles total), pen accepted only after clr_done.
- rst_n asserted at clear cycle 30 → clr_busy=0 and ram_we=0 immediately; cells 0..29 read 0, cells 30..63 retain prior data.
